// File: rtl/mop_issue_pipe_if.sv
// Sequencer-to-issue-pipe micro-op channel (valid/ready handshake plus op fields).
interface mop_issue_pipe_if #(
    parameter int unsigned AW     = 9,
    parameter int unsigned CSIG_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     in_src0;
    logic [AW-1:0]     in_src1;
    logic [AW-1:0]     in_dst;
    logic [1:0]        in_we;
    logic [CSIG_W-1:0] in_csig;

    modport master (
        output in_valid, in_src0, in_src1, in_dst, in_we, in_csig,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_src0, in_src1, in_dst, in_we, in_csig,
        output in_ready
    );
endinterface

// File: rtl/mop_issue_pipe.sv
// Micro-op issue and tracking pipeline: delay line with stage taps, RAW/WAW scoreboard
// that stalls issue, and a fixed-priority shared BRAM write port (host > pipe > side).
// Optional stall performance counter enabled by defining MOP_PERF_CNT_EN.
module mop_issue_pipe #(
    parameter int unsigned AW        = 9,
    parameter int unsigned CSIG_W    = 16,
    parameter int unsigned LAT_READ  = 2,
    parameter int unsigned LAT_EXEC  = 90,
    parameter int unsigned TAP_CMUL  = 88,
    parameter int unsigned LAT_WRITE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              host_mode,
    mop_issue_pipe_if.slave   op,
    output logic [AW-1:0]     rd_addr0,
    output logic [AW-1:0]     rd_addr1,
    input  logic              ext_we,
    input  logic [AW-1:0]     ext_waddr,
    input  logic [AW-1:0]     ext_raddr,
    output logic [CSIG_W-1:0] pre_csig,
    output logic [CSIG_W-1:0] cmul_csig,
    output logic [CSIG_W-1:0] post_csig,
    output logic [CSIG_W-1:0] post2_csig,
    input  logic              sw_req,
    input  logic [AW-1:0]     sw_addr,
    output logic              sw_gnt,
    output logic [1:0]        mem_we,
    output logic [AW-1:0]     mem_waddr,
    output logic [1:0]        mem_sel,
    output logic [23:0]       stall_cnt
);
    localparam int unsigned P     = LAT_READ + LAT_EXEC + LAT_WRITE;
    localparam int unsigned NADDR = 1 << AW;

    logic [P-1:0]      vld_q;
    logic [AW-1:0]     dst_q  [P];
    logic [1:0]        we_q   [P];
    logic [CSIG_W-1:0] csig_q [P];
    logic [NADDR-1:0]  pend_q;
    logic [NADDR-1:0]  pend_d;
    logic              fire;
    logic              wb_clr;

    // Hazards use the registered scoreboard only; a clear takes effect next cycle.
    assign op.in_ready = ~host_mode & ~rst & ~flush & ~pend_q[op.in_src0]
                       & ~pend_q[op.in_src1] & ~pend_q[op.in_dst];
    assign fire = op.in_valid & op.in_ready;

    assign rd_addr0 = op.in_src0;
    assign rd_addr1 = host_mode ? ext_raddr : op.in_src1;

    assign pre_csig   = vld_q[LAT_READ]   ? csig_q[LAT_READ]   : '0;
    assign cmul_csig  = vld_q[TAP_CMUL]   ? csig_q[TAP_CMUL]   : '0;
    assign post_csig  = vld_q[TAP_CMUL+1] ? csig_q[TAP_CMUL+1] : '0;
    assign post2_csig = vld_q[TAP_CMUL+2] ? csig_q[TAP_CMUL+2] : '0;

    // Only ops that actually set a pend bit may clear one (a we=0 op must not release a
    // later writer's reservation on the same address).
    assign wb_clr = vld_q[P-1] & (we_q[P-1] != 2'b00);

    // Delay line: shift every cycle, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q <= '0;
            for (int k = 0; k < P; k++) begin
                dst_q[k]  <= '0;
                we_q[k]   <= '0;
                csig_q[k] <= '0;
            end
        end else begin
            vld_q     <= {vld_q[P-2:0], fire};
            dst_q[0]  <= fire ? op.in_dst  : '0;
            we_q[0]   <= fire ? op.in_we   : '0;
            csig_q[0] <= fire ? op.in_csig : '0;
            for (int k = 1; k < P; k++) begin
                dst_q[k]  <= dst_q[k-1];
                we_q[k]   <= we_q[k-1];
                csig_q[k] <= csig_q[k-1];
            end
        end
    end

    // Scoreboard next state: clear on write-back, set on issue of a writing op.
    always_comb begin
        pend_d = pend_q;
        if (wb_clr) begin
            pend_d[dst_q[P-1]] = 1'b0;
        end
        if (fire && (op.in_we != 2'b00)) begin
            pend_d[op.in_dst] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Write port arbitration: host write, then pipeline write-back, then side unit.
    always_comb begin
        mem_we    = 2'b00;
        mem_waddr = '0;
        mem_sel   = 2'd0;
        sw_gnt    = 1'b0;
        if (rst) begin
            mem_we = 2'b00;
        end else if (host_mode && ext_we) begin
            mem_we    = 2'b11;
            mem_waddr = ext_waddr;
            mem_sel   = 2'd0;
        end else if (vld_q[P-1] && !flush) begin
            mem_we    = we_q[P-1];
            mem_waddr = dst_q[P-1];
            mem_sel   = 2'd2;
        end else if (sw_req) begin
            mem_we    = 2'b11;
            mem_waddr = sw_addr;
            mem_sel   = 2'd1;
            sw_gnt    = 1'b1;
        end
    end

`ifdef MOP_PERF_CNT_EN
    logic [23:0] stall_q;

    // Saturating count of cycles the sequencer was held off by hazards or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (op.in_valid && !op.in_ready && !host_mode && (stall_q != 24'hFFFFFF)) begin
            stall_q <= stall_q + 24'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif
endmodule
